// File: rtl/light_decoder.sv
// Receive side of the LED optical link: synchronises the photo-sensor line,
// recovers start/data/stop framing and presents each packet as a parallel word.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module light_decoder #(
  parameter int unsigned PACKET_SIZE = `PACKET_SIZE,
  parameter int unsigned BIT_TICKS   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sensor,
  output logic [PACKET_SIZE-1:0] data,
  output logic                   valid,
  output logic                   error,
  output logic                   busy
);

  localparam int unsigned CW = $clog2(BIT_TICKS);
  localparam int unsigned IW = $clog2(PACKET_SIZE + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TICKS / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PACKET_SIZE - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [PACKET_SIZE-1:0] shift_q, shift_d;
  logic [PACKET_SIZE-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;

  // Synchroniser resets high so a line already lit at reset release is not
  // mistaken for a fresh start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sensor;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        if (!s_q) state_d = IDLE;
      end

      IDLE: begin
        if (s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      // Half a bit into the start bit the line must still be high; this also
      // aligns every later sample to mid-bit.
      START: begin
        if (cnt_q == HALF_LAST) begin
          if (s_q) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d = {shift_q[PACKET_SIZE-2:0], s_q};
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (!s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            error_d = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = WAIT_IDLE;
    endcase

    busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign error = error_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_light_decoder.sv
// Bench for light_decoder: per-edge expectation tables built from frame start
// edges and the frame latency, checked every cycle, plus literal spot checks.
module tb_light_decoder;

  localparam int P    = 8;
  localparam int BT   = 4;
  localparam int LAT  = 2 + BT / 2 + (P + 1) * BT;
  localparam int P2   = 16;
  localparam int BT2  = 8;
  localparam int LAT2 = 2 + BT2 / 2 + (P2 + 1) * BT2;
  localparam int N    = 2000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          sensor = 1'b0;
  logic          sensor2 = 1'b0;
  logic [P-1:0]  data;
  logic          valid, error, busy;
  logic [P2-1:0] data2;
  logic          valid2, error2, busy2;

  light_decoder dut (
    .clock (clock),
    .reset (reset),
    .sensor(sensor),
    .data  (data),
    .valid (valid),
    .error (error),
    .busy  (busy)
  );

  light_decoder #(.PACKET_SIZE(P2), .BIT_TICKS(BT2)) dut2 (
    .clock (clock),
    .reset (reset),
    .sensor(sensor2),
    .data  (data2),
    .valid (valid2),
    .error (error2),
    .busy  (busy2)
  );

  always #5 clock = ~clock;

  // cyc holds the number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit       exp_valid [N];
  bit       exp_error [N];
  bit       exp_busy  [N];
  logic [P-1:0] exp_data [N];

  int       e2_valid_edge = N;
  int       reset_edge2   = N;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cyc < N) begin
      check("valid", valid, exp_valid[cyc]);
      check("error", error, exp_error[cyc]);
      check("busy",  busy,  exp_busy[cyc]);
      check("data",  data,  exp_data[cyc]);
      check("valid2", valid2, (cyc == e2_valid_edge) ? 1 : 0);
      check("error2", error2, 0);
      check("data2",  data2,
            (cyc >= e2_valid_edge && cyc < reset_edge2) ? 32'h0000_A55A : 32'h0);
    end
  end

  task automatic sched_frame(input int e, input logic [P-1:0] d, input bit ok);
    for (int k = e + 2; k < e + LAT; k++) exp_busy[k] = 1'b1;
    if (ok) begin
      exp_valid[e + LAT] = 1'b1;
      for (int k = e + LAT; k < N; k++) exp_data[k] = d;
    end else begin
      exp_error[e + LAT] = 1'b1;
    end
  endtask

  task automatic sched_reset(input int r);
    for (int k = r; k < N; k++) begin
      exp_busy[k]  = 1'b0;
      exp_valid[k] = 1'b0;
      exp_error[k] = 1'b0;
      exp_data[k]  = '0;
    end
  endtask

  // Each call sets the level sampled at the next n rising edges.
  task automatic drive(input bit b, input int n);
    repeat (n) begin
      sensor = b;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [P-1:0] d, input bit stop_lvl, output int e);
    e = cyc + 1;
    sched_frame(e, d, !stop_lvl);
    drive(1'b1, BT);
    for (int i = P - 1; i >= 0; i--) drive(d[i], BT);
    drive(stop_lvl, BT);
  endtask

  initial begin
    int e, e2;
    for (int k = 0; k < N; k++) exp_data[k] = '0;
    reset  = 1'b0;
    sensor = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b0, 4);

    // 1: single frame, literal pin on the valid cycle
    send(8'hB6, 1'b0, e);
    @(posedge clock);
    #1;
    check("t1_valid_lit", valid, 1);
    check("t1_data_lit",  data,  8'hB6);
    check("t1_busy_lit",  busy,  0);
    drive(1'b0, 4);

    // 2: back-to-back frames
    send(8'hB6, 1'b0, e);
    send(8'h01, 1'b0, e2);
    @(posedge clock);
    #1;
    check("t2_valid_lit", valid, 1);
    check("t2_data_lit",  data,  8'h01);
    drive(1'b0, 4);

    // 3: one-cycle glitch, then a clean frame
    e = cyc + 1;
    for (int k = e + 2; k <= e + 3; k++) exp_busy[k] = 1'b1;
    drive(1'b1, 1);
    drive(1'b0, 4);
    check("t3_busy_lit", busy, 0);
    drive(1'b0, 2);
    send(8'h5A, 1'b0, e);
    drive(1'b0, 4);

    // 4: stop bit high, line stays high, then recovery
    send(8'hB6, 1'b1, e);
    drive(1'b1, 1);
    check("t4_error_lit", error, 1);
    check("t4_valid_lit", valid, 0);
    check("t4_data_lit",  data,  8'h5A);
    drive(1'b1, 11);
    drive(1'b0, 4);
    send(8'hC3, 1'b0, e);
    drive(1'b0, 4);

    // 5: reset mid-frame with the line held high through release
    e = cyc + 1;
    for (int k = e + 2; k < e + 19; k++) exp_busy[k] = 1'b1;
    drive(1'b1, 20);
    sched_reset(cyc);
    reset_edge2 = cyc;
    reset = 1'b0;
    #1;
    check("t5_busy_rst", busy, 0);
    check("t5_data_rst", data, 0);
    drive(1'b1, 4);
    reset = 1'b1;
    drive(1'b1, 10);
    check("t5_busy_held", busy, 0);
    drive(1'b0, 4);
    send(8'h3C, 1'b0, e);
    drive(1'b0, 4);

    // 6: all-zero and all-one payloads
    send(8'h00, 1'b0, e);
    send(8'hFF, 1'b0, e);
    drive(1'b0, 6);
    check("t6_data_lit", data, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Wide instance: one 16-bit frame starting at edge 9, valid expected at 9+142.
  initial begin
    logic [P2-1:0] w;
    w = 16'hA55A;
    repeat (8) @(posedge clock);
    #1;
    e2_valid_edge = cyc + 1 + LAT2;
    for (int i = 0; i < BT2; i++) begin
      sensor2 = 1'b1; @(posedge clock); #1;
    end
    for (int b = P2 - 1; b >= 0; b--) begin
      for (int i = 0; i < BT2; i++) begin
        sensor2 = w[b]; @(posedge clock); #1;
      end
    end
    for (int i = 0; i < BT2 - 1; i++) begin
      sensor2 = 1'b0; @(posedge clock); #1;
    end
    check("w_edge_lit",  cyc,    151);
    check("w_valid_lit", valid2, 1);
    check("w_data_lit",  data2,  16'hA55A);
    sensor2 = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL timeout: edge %0d reached without completing", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/light_decoder.md
Name: light_decoder

Overview:
- Receive end of the LED optical link: recovers packets that the encoder serialises onto the LED.
- Takes the 1-bit photo-sensor line and synchronises it into the clock domain.
- Detects the start bit, samples each bit at mid-period and checks the stop bit.
- Presents each recovered packet as a parallel word with a one-cycle valid strobe, or flags a framing error.

Parameters:
- PACKET_SIZE, default `PACKET_SIZE (8): data bits per frame.
- BIT_TICKS, default 4: clock cycles per bit on the line. Must be even and >= 4; must match the encoder setting.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- sensor  input  1  raw light-sensor level (1 = LED on); asynchronous to clock.
- data  output  PACKET_SIZE  last correctly framed packet, MSB = first data bit on the line.
- valid  output  1  one-cycle pulse: data has just been updated.
- error  output  1  one-cycle pulse: stop bit was not 0.
- busy  output  1  high while a frame is being received (START, DATA, STOP).

Behaviour:
- Line format: idle = 0; start bit = 1; PACKET_SIZE data bits, MSB first; stop bit = 0. Each bit lasts BIT_TICKS cycles. Back-to-back frames are allowed, with the next start bit immediately after the stop bit.
- Synchroniser: two flops, sync1 then s. Both reset to 1.
- Reset (reset=0, async) clears everything immediately:
  - data=0, valid=0, error=0, busy=0
  - cnt=0, bit index=0, shift register=0
  - state=WAIT_IDLE
- States:
  - WAIT_IDLE: when s==0, go to IDLE. Guards against a line held high at reset release or after an error.
  - IDLE: when s==1, go to START with cnt=0.
  - START: if cnt==BIT_TICKS/2-1, check s. If s==1, go to DATA with cnt=0 and bit index=0. If s==0 it was a glitch: go to IDLE with no error. Otherwise cnt++.
  - DATA: if cnt==BIT_TICKS-1, shift left with s into the LSB, set cnt=0 and bit index++. After the PACKET_SIZE-th sample, go to STOP. Otherwise cnt++.
  - STOP: if cnt==BIT_TICKS-1, check s:
    - s==0: data<=shift register, valid=1 for one cycle, go to IDLE.
    - s==1: error=1 for one cycle, data unchanged, go to WAIT_IDLE.
    - Otherwise cnt++.
- valid and error are registered, never asserted together, and low in all other cycles.
- busy is registered and equals (state is START, DATA or STOP).
- Latency: let E be the first rising edge at which sensor is sampled high. valid rises at edge E + 2 + BIT_TICKS/2 + (PACKET_SIZE+1)*BIT_TICKS. With defaults that is E+40.
- Sampling points fall at mid-bit, accounting for the 2-cycle synchroniser delay.
- The decoder reaches IDLE half a bit before the stop bit ends; the rest of the stop bit reads 0 and is ignored.
- Reset mid-frame: the partial frame is discarded and no valid or error is raised. Reception re-arms only after the line has been seen at 0.
- Counter widths: cnt is $clog2(BIT_TICKS) bits; bit index is $clog2(PACKET_SIZE+1) bits. No wrap is reachable.

Test Plan:
1. Defaults, one frame carrying 8'b1011_0110, sensor starts high before edge 1 → valid high only in the cycle after edge 41, data=8'hB6, error never high, busy high from edge 3 to edge 41.
2. Back-to-back frames 8'hB6 then 8'h01 with no idle gap → valid at edges 41 and 81, data=8'hB6 then 8'h01, no error.
3. One-cycle glitch (sensor high before edge 1 only) → busy high edges 3–5 then 0, no valid, no error, data unchanged; a following clean 8'h5A frame decodes correctly.
4. Frame 8'hB6 with the stop bit and all following cycles held at 1 → error pulse at edge 41, valid 0, data keeps its prior value. No further activity until the line goes to 0; then a frame 8'hC3 yields valid with data=8'hC3.
5. Reset to 0 at edge 20 mid-frame, released at edge 24 while the line is still high → outputs 0 immediately, no valid/error for the aborted frame, decoder stays in WAIT_IDLE until the line goes low; the next frame 8'h3C decodes.
6. Frames 8'h00 and 8'hFF, plus PACKET_SIZE=16 / BIT_TICKS=8 with 16'hA55A → correct data and valid timing per the latency formula (edge 1 + 2 + 4 + 17*8 = 143), no error.
